gyruss_lpf_sched: RTL and testbench



---
 rtl/gyruss_lpf_pkg.sv | 47 ++++
 rtl/gyruss_lpf_mac.sv | 42 ++++
 rtl/gyruss_lpf_sched.sv | 205 ++++++++++++++++++++
 tb/tb_gyruss_lpf_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gyruss_lpf_pkg.sv
// Shared types, constants and helpers for the Gyruss low-pass scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gyruss_lpf_pkg;

   // Frame-walk states: one LATCH, four steps per channel, one DONE.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_MB1,
      S_MB2,
      S_MA2,
      S_WB,
      S_DONE
   } state_t;

   // Accumulator operation for the shared MAC.
   typedef enum logic [1:0] {
      OP_HOLD,
      OP_MUL,
      OP_ADD,
      OP_SUB
   } mac_op_t;

   // Default coefficients: unity DC gain because 2*135 = 32768 - 32498.
   localparam int DEF_A2 = -32498;
   localparam int DEF_B  = 135;

   localparam logic [1:0] CFG_SEL_B1 = 2'd0;
   localparam logic [1:0] CFG_SEL_B2 = 2'd1;
   localparam logic [1:0] CFG_SEL_A2 = 2'd2;

   // Coefficients are Q2.15, so results are scaled back by 15 bits.
   localparam int SHIFT = 15;

   // Clamp a wide signed value into the 16-bit sample range.
   function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
      if (v > 64'sd32767) begin
         return 16'sh7fff;
      end
      if (v < -64'sd32768) begin
         return 16'sh8000;
      end
      return v[15:0];
   endfunction

endpackage

// File: rtl/gyruss_lpf_mac.sv
// Registered signed multiply-accumulate with a saturating Q15 output view.
// Latency: one cycle from op to updated accumulator; y follows acc combinationally.
// Backpressure: none; the scheduler issues at most one op per cycle.
module gyruss_lpf_mac
   import gyruss_lpf_pkg::*;
#(
   parameter int CW = 18,
   parameter int AW = 16 + CW + 3
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  mac_op_t              op,
   input  logic signed [15:0]   a,
   input  logic signed [CW-1:0] b,
   output logic signed [15:0]   y
);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] prod;

   // Full-width product; both operands sign-extended so nothing is lost.
   assign prod = AW'(a) * AW'(b);

   // Accumulator update: clear-and-load, add or subtract the product.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
      end else begin
         case (op)
            OP_MUL:  acc <= prod;
            OP_ADD:  acc <= acc + prod;
            OP_SUB:  acc <= acc - prod;
            default: acc <= acc;
         endcase
      end
   end

   // Arithmetic shift floors toward negative infinity before clamping.
   assign y = sat16(64'(acc >>> SHIFT));

endmodule

// File: rtl/gyruss_lpf_sched.sv
// Time-multiplexed first-order IIR over all sound channels on one shared MAC.
// Latency: out_valid 4*CHANNELS+1 cycles after LATCH; one frame per sample tick.
// Backpressure: none; a tick arriving mid-frame is dropped and flags overrun.
module gyruss_lpf_sched #(
   parameter int CHANNELS = 5,
   parameter int DIV      = 220,
   parameter int CW       = 18,
   parameter int DEF_A2   = gyruss_lpf_pkg::DEF_A2,
   parameter int DEF_B    = gyruss_lpf_pkg::DEF_B
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [16*CHANNELS-1:0]  in,
   input  logic                    cfg_we,
   input  logic [2:0]              cfg_ch,
   input  logic [1:0]              cfg_sel,
   input  logic signed [CW-1:0]    cfg_data,
   output logic [16*CHANNELS-1:0]  out,
   output logic                    out_valid,
   output logic                    busy,
   output logic                    overrun
);
   import gyruss_lpf_pkg::*;

   localparam int         CNTW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [2:0] LAST = 3'(CHANNELS - 1);
   localparam logic [3:0] NCH  = 4'(CHANNELS);

   state_t               state, state_n;
   logic [CNTW-1:0]      cnt;
   logic                 tick;
   logic [2:0]           ch;

   logic signed [15:0]   frame [CHANNELS];
   logic signed [15:0]   x1    [CHANNELS];
   logic signed [15:0]   y1    [CHANNELS];
   logic signed [15:0]   out_r [CHANNELS];

   logic signed [CW-1:0] act_b1 [CHANNELS];
   logic signed [CW-1:0] act_b2 [CHANNELS];
   logic signed [CW-1:0] act_a2 [CHANNELS];
   logic signed [CW-1:0] sh_b1  [CHANNELS];
   logic signed [CW-1:0] sh_b2  [CHANNELS];
   logic signed [CW-1:0] sh_a2  [CHANNELS];

   mac_op_t              mac_op;
   logic signed [15:0]   mac_a;
   logic signed [CW-1:0] mac_b;
   logic signed [15:0]   mac_y;

   assign tick = (cnt == CNTW'(DIV - 1));

   // Free-running sample-tick divider.
   always_ff @(posedge clk) begin
      if (reset || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNTW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state, MAC operand routing and status outputs.
   always_comb begin
      state_n   = state;
      mac_op    = OP_HOLD;
      mac_a     = '0;
      mac_b     = '0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (tick) state_n = S_LATCH;
         end
         S_LATCH: begin
            busy    = 1'b1;
            state_n = S_MB1;
         end
         S_MB1: begin
            busy    = 1'b1;
            mac_op  = OP_MUL;
            mac_a   = frame[ch];
            mac_b   = act_b1[ch];
            state_n = S_MB2;
         end
         S_MB2: begin
            busy    = 1'b1;
            mac_op  = OP_ADD;
            mac_a   = x1[ch];
            mac_b   = act_b2[ch];
            state_n = S_MA2;
         end
         S_MA2: begin
            busy    = 1'b1;
            mac_op  = OP_SUB;
            mac_a   = y1[ch];
            mac_b   = act_a2[ch];
            state_n = S_WB;
         end
         S_WB: begin
            busy    = 1'b1;
            state_n = (ch == LAST) ? S_DONE : S_MB1;
         end
         S_DONE: begin
            out_valid = 1'b1;
            // With the tightest legal DIV the next tick lands exactly here.
            state_n   = tick ? S_LATCH : S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   gyruss_lpf_mac #(
      .CW (CW)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .op    (mac_op),
      .a     (mac_a),
      .b     (mac_b),
      .y     (mac_y)
   );

   // Coefficient banks: writes always hit shadow; LATCH publishes shadow to active.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < CHANNELS; k++) begin
            sh_b1[k]  <= CW'(DEF_B);
            sh_b2[k]  <= CW'(DEF_B);
            sh_a2[k]  <= CW'(DEF_A2);
            act_b1[k] <= CW'(DEF_B);
            act_b2[k] <= CW'(DEF_B);
            act_a2[k] <= CW'(DEF_A2);
         end
      end else begin
         if (state == S_LATCH) begin
            for (int k = 0; k < CHANNELS; k++) begin
               act_b1[k] <= sh_b1[k];
               act_b2[k] <= sh_b2[k];
               act_a2[k] <= sh_a2[k];
            end
         end
         if (cfg_we && ({1'b0, cfg_ch} < NCH)) begin
            case (cfg_sel)
               CFG_SEL_B1: sh_b1[cfg_ch] <= cfg_data;
               CFG_SEL_B2: sh_b2[cfg_ch] <= cfg_data;
               CFG_SEL_A2: sh_a2[cfg_ch] <= cfg_data;
               default:    ;
            endcase
         end
      end
   end

   // Frame snapshot, channel index and per-channel history/output write-back.
   always_ff @(posedge clk) begin
      if (reset) begin
         ch <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            frame[k] <= '0;
            x1[k]    <= '0;
            y1[k]    <= '0;
            out_r[k] <= '0;
         end
      end else begin
         case (state)
            S_LATCH: begin
               ch <= '0;
               for (int k = 0; k < CHANNELS; k++) begin
                  frame[k] <= in[16*k +: 16];
               end
            end
            S_WB: begin
               out_r[ch] <= mac_y;
               y1[ch]    <= mac_y;
               x1[ch]    <= frame[ch];
               if (ch != LAST) ch <= ch + 3'd1;
            end
            default: ;
         endcase
      end
   end

   // Sticky flag for a tick that arrived while a frame was still running.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (tick && busy) begin
         overrun <= 1'b1;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign out[16*g +: 16] = out_r[g];
   end

endmodule

// File: tb/tb_gyruss_lpf_sched.sv
// Directed bench for gyruss_lpf_sched: vector table plus multi-cycle corner sequences.
// Latency: checks 21-cycle LATCH-to-valid and 220-cycle frame period.
// Backpressure: exercises the overrun path with an undersized divider.
module tb_gyruss_lpf_sched;

   localparam int NCH = 5;
   localparam int W   = 16 * NCH;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;

   // Main instance (DIV=220), fast instance (DIV=22, tightest legal), overrun instance (DIV=10).
   logic                rst_m = 1'b1, rst_f = 1'b1, rst_o = 1'b1;
   logic [W-1:0]        in_m = '0, in_f = '0, in_o = '0;
   logic                cfg_we = 1'b0;
   logic [2:0]          cfg_ch = '0;
   logic [1:0]          cfg_sel = '0;
   logic signed [17:0]  cfg_data = '0;
   logic                z_we = 1'b0;
   logic [2:0]          z_ch = '0;
   logic [1:0]          z_sel = '0;
   logic signed [17:0]  z_data = '0;
   logic [W-1:0]        out_m, out_f, out_o;
   logic                vld_m, busy_m, ovr_m;
   logic                vld_f, busy_f, ovr_f;
   logic                vld_o, busy_o, ovr_o;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gyruss_lpf_sched #(.CHANNELS(NCH), .DIV(220)) u_main (
      .clk(clk), .reset(rst_m), .in(in_m), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_sel(cfg_sel), .cfg_data(cfg_data), .out(out_m), .out_valid(vld_m),
      .busy(busy_m), .overrun(ovr_m));

   gyruss_lpf_sched #(.CHANNELS(NCH), .DIV(22)) u_fast (
      .clk(clk), .reset(rst_f), .in(in_f), .cfg_we(z_we), .cfg_ch(z_ch),
      .cfg_sel(z_sel), .cfg_data(z_data), .out(out_f), .out_valid(vld_f),
      .busy(busy_f), .overrun(ovr_f));

   gyruss_lpf_sched #(.CHANNELS(NCH), .DIV(10)) u_ov (
      .clk(clk), .reset(rst_o), .in(in_o), .cfg_we(z_we), .cfg_ch(z_ch),
      .cfg_sel(z_sel), .cfg_data(z_data), .out(out_o), .out_valid(vld_o),
      .busy(busy_o), .overrun(ovr_o));

   typedef struct packed {
      logic [NCH-1:0][15:0] x;
      logic [NCH-1:0][15:0] e;
   } vec_t;

   function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3, input int x4,
                               input int e0, input int e1, input int e2, input int e3, input int e4);
      vec_t v;
      v.x[0] = 16'(x0); v.x[1] = 16'(x1); v.x[2] = 16'(x2); v.x[3] = 16'(x3); v.x[4] = 16'(x4);
      v.e[0] = 16'(e0); v.e[1] = 16'(e1); v.e[2] = 16'(e2); v.e[3] = 16'(e3); v.e[4] = 16'(e4);
      return v;
   endfunction

   function automatic logic signed [15:0] lane(input logic [W-1:0] v, input int k);
      return v[16*k +: 16];
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic reset_main();
      @(negedge clk);
      rst_m = 1'b1;
      repeat (2) @(negedge clk);
      rst_m = 1'b0;
   endtask

   task automatic cfg_write(input logic [2:0] c, input logic [1:0] s, input int d);
      cfg_we = 1'b1; cfg_ch = c; cfg_sel = s; cfg_data = 18'(d);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // One frame on the main instance: drive inputs, find LATCH, await out_valid, compare lanes.
   // With do_cfg, ch3 A2 is rewritten starting in the LATCH cycle, followed by two writes
   // that must be ignored (reserved select, out-of-range channel).
   task automatic run_frame(input vec_t v, input string tag, input bit do_cfg,
                            input int prev_v, output int vcyc);
      int t0;
      bit seen;
      for (int k = 0; k < NCH; k++) in_m[16*k +: 16] = v.x[k];
      vcyc = 0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (busy_m) seen = 1'b1;
      end
      chk($sformatf("%s_latch_seen", tag), seen, 1);
      if (!seen) return;
      t0 = cyc;
      if (do_cfg) begin
         cfg_we = 1'b1; cfg_ch = 3'd3; cfg_sel = 2'd2; cfg_data = -18'sd16384;
         @(negedge clk);
         cfg_sel = 2'd3; cfg_data = '0;
         @(negedge clk);
         cfg_ch = 3'd6; cfg_sel = 2'd2;
         @(negedge clk);
         cfg_we = 1'b0;
      end
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (vld_m) seen = 1'b1;
         else @(negedge clk);
      end
      chk($sformatf("%s_valid_seen", tag), seen, 1);
      if (!seen) return;
      vcyc = cyc;
      chk($sformatf("%s_latency", tag), vcyc - t0, 21);
      if (prev_v > 0) chk($sformatf("%s_period", tag), vcyc - prev_v, 220);
      for (int k = 0; k < NCH; k++)
         chk($sformatf("%s_out%0d", tag, k), lane(out_m, k), $signed(v.e[k]));
      @(negedge clk);
      chk($sformatf("%s_pulse_width", tag), vld_m, 0);
   endtask

   initial begin
      vec_t         tbl [6];
      int           pv, vc, cnt_v, viol, over, oth, got, first_y, prev_y;
      bit           seen;
      logic signed [15:0] y;
      logic [W-1:0] m;

      // Default coefficients B1=B2=135, A2=-32498; y = floor((135x + 135x1 + 32498y1) / 2^15).
      tbl[0] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 0);
      tbl[1] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 0);
      tbl[2] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 0);
      // 135*16384 = 2211840 -> 67.5 -> 67 ; negative side floors to -68.
      tbl[3] = mk(16384, 0, 0, 0, -16384, 67, 0, 0, 0, -68);
      // 2211840 + 32498*67 = 4389206 -> 133.95 -> 133 ; lane4 -4421704 -> -135.
      tbl[4] = mk(0, 0, 0, 0, 0,          133, 0, 0, 0, -135);
      // lane0 32498*133 = 4322234 -> 131 ; lane1 135*32767 -> 134 ; lane4 -4387230 -> -134.
      tbl[5] = mk(0, 32767, 0, 0, 0,      131, 134, 0, 0, -134);

      // Overrun: DIV=10 cannot fit a 21-cycle frame; second tick lands mid-frame.
      repeat (2) @(negedge clk);
      rst_o = 1'b0;
      repeat (14) @(negedge clk);
      chk("ov_busy_first_frame", busy_o, 1);
      chk("ov_clear_before_2nd_tick", ovr_o, 0);
      repeat (11) @(negedge clk);
      chk("ov_set_after_2nd_tick", ovr_o, 1);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (vld_o) seen = 1'b1;
      end
      chk("ov_frame_completes", seen, 1);
      repeat (100) @(negedge clk);
      chk("ov_sticky", ovr_o, 1);
      rst_o = 1'b1;
      @(negedge clk);
      rst_o = 1'b0;
      @(negedge clk);
      chk("ov_cleared_by_reset", ovr_o, 0);

      // Reset state of the main instance.
      rst_m = 1'b0;
      @(negedge clk);
      chk("reset_out_nonzero", (out_m != '0), 0);
      chk("reset_busy", busy_m, 0);
      chk("reset_out_valid", vld_m, 0);
      chk("reset_overrun", ovr_m, 0);

      // Vector table: consecutive frames, latency/period/pulse width checked each frame.
      pv = 0;
      for (int i = 0; i < 6; i++) begin
         run_frame(tbl[i], $sformatf("vec%0d", i), 1'b0, pv, vc);
         pv = vc;
      end
      chk("no_overrun_legal_div", ovr_m, 0);

      // Saturation on ch1 with B1=B2=32767, A2=0.
      reset_main();
      cfg_write(3'd1, 2'd0, 32767);
      cfg_write(3'd1, 2'd1, 32767);
      cfg_write(3'd1, 2'd2, 0);
      // 32767^2 = 1073676289 -> 32766.00003 -> 32766 (just inside range)
      run_frame(mk(0, 32767, 0, 0, 0, 0, 32766, 0, 0, 0), "sat1", 1'b0, 0, vc);
      // 2*32767^2 -> 65532 -> clamps to 32767
      run_frame(mk(0, 32767, 0, 0, 0, 0, 32767, 0, 0, 0), "sat2", 1'b0, vc, vc);
      // 32767*(-32768) + 32767*32767 = -32767 -> floor -> -1
      run_frame(mk(0, -32768, 0, 0, 0, 0, -1, 0, 0, 0), "sat3", 1'b0, vc, vc);
      // 2*32767*(-32768) -> -65534 -> clamps to -32768
      run_frame(mk(0, -32768, 0, 0, 0, 0, -32768, 0, 0, 0), "sat4", 1'b0, vc, vc);

      // Shadow bank: A2 of ch3 rewritten during frame B takes effect only in frame C.
      reset_main();
      run_frame(mk(0, 0, 0, 16384, 0, 0, 0, 0, 67, 0), "cfgA", 1'b0, 0, vc);
      run_frame(mk(0, 0, 0, 0, 0, 0, 0, 0, 133, 0), "cfgB", 1'b1, vc, vc);
      // 16384*133 = 2179072 -> 66.5 -> 66 (old A2 would give 131)
      run_frame(mk(0, 0, 0, 0, 0, 0, 0, 0, 66, 0), "cfgC", 1'b0, vc, vc);

      // Reset during MA2 of ch2 aborts the frame with no out_valid.
      reset_main();
      run_frame(tbl[3], "pre", 1'b0, 0, vc);
      in_m = '0;
      in_m[15:0] = 16'sd1000;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (busy_m) seen = 1'b1;
      end
      chk("mid_latch_seen", seen, 1);
      repeat (11) @(negedge clk);
      chk("mid_out_nonzero_before", (out_m != '0), 1);
      rst_m = 1'b1;
      @(negedge clk);
      chk("mid_out_cleared", (out_m != '0), 0);
      chk("mid_busy_cleared", busy_m, 0);
      chk("mid_no_valid", vld_m, 0);
      rst_m = 1'b0;
      cnt_v = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (vld_m) cnt_v++;
      end
      chk("mid_no_valid_after", cnt_v, 0);
      run_frame(tbl[3], "cold", 1'b0, 0, vc);

      // DC 1000 on ch2 for 2000 frames on the DIV=22 instance. The floor in the
      // recurrence advances y by floor(270*(1000-y)/32768) per frame, which stops
      // once 1000-y <= 121, so the output settles at 879 from below.
      in_f[32 +: 16] = 16'sd1000;
      @(negedge clk);
      rst_f = 1'b0;
      viol = 0; over = 0; oth = 0; got = 0; first_y = -1; prev_y = 0;
      for (int n = 0; n < 2000; n++) begin
         seen = 1'b0;
         for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (vld_f) seen = 1'b1;
         end
         if (!seen) break;
         got++;
         y = lane(out_f, 2);
         if (n == 0) first_y = y;
         if (y < prev_y) viol++;
         if (y > 1000) over++;
         m = out_f;
         m[32 +: 16] = '0;
         if (m != '0) oth++;
         prev_y = y;
      end
      chk("dc_frames", got, 2000);
      chk("dc_first", first_y, 4);
      chk("dc_monotonic_violations", viol, 0);
      chk("dc_above_1000", over, 0);
      chk("dc_other_lanes_nonzero", oth, 0);
      chk("dc_final", prev_y, 879);
      chk("dc_no_overrun_tight_div", ovr_f, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion, expected end of test");
      $fatal(1);
   end

endmodule
